// File: rtl/round_cipher_core_if.sv
// Block handshake between the UART controller (master) and the round cipher core (slave).
// Din/Din_valid flow to the core; Dout/Dout_valid/busy flow back to the controller.
interface round_cipher_core_if;
  logic         Din_valid;
  logic [127:0] Din;
  logic         Dout_valid;
  logic [127:0] Dout;
  logic         busy;

  modport master (output Din_valid, output Din, input Dout_valid, input Dout, input busy);
  modport slave  (input Din_valid, input Din, output Dout_valid, output Dout, output busy);
endinterface

// File: rtl/round_cipher_core.sv
// Iterative 128-bit keyed round core: one key-mix/rotate/add round per clock, 1-cycle result pulse.
// Optional CIPHER_OVERRUN_EN adds a sticky `overrun` flag for starts that arrive while busy.
module round_cipher_core #(
  parameter int unsigned  ROUNDS  = 10,
  parameter logic [127:0] KEY     = 128'h000102030405060708090A0B0C0D0E0F,
  parameter logic [7:0]   RC_INIT = 8'h01
) (
  input logic               clk,
  input logic               rst,
  round_cipher_core_if.slave cipher_if
`ifdef CIPHER_OVERRUN_EN
  ,
  output logic              overrun
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

  state_t       state_q, state_d;
  logic [127:0] s_q, s_d;
  logic [127:0] dout_q, dout_d;
  logic [4:0]   r_q, r_d;
  logic [7:0]   rc_q, rc_d;
  logic         din_valid_q;
  logic         start;
  logic [127:0] rk;
  logic [127:0] mix;
  logic [127:0] round_out;
  logic [7:0]   rc_step;

  // Key rotations are constant, so all 16 byte-offsets are precomputed and muxed by r mod 16.
  logic [127:0] key_rot [16];
  for (genvar gi = 0; gi < 16; gi++) begin : g_key_rot
    assign key_rot[gi] = (KEY << (8 * gi)) | (KEY >> (128 - 8 * gi));
  end

  assign start     = cipher_if.Din_valid & ~din_valid_q;
  assign rk        = key_rot[r_q[3:0]] ^ {120'b0, rc_q};
  assign mix       = s_q ^ rk;
  assign round_out = {mix[114:0], mix[127:115]} + rk;
  assign rc_step   = {rc_q[6:0], 1'b0} ^ (rc_q[7] ? 8'h1B : 8'h00);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    dout_d  = dout_q;
    r_d     = r_q;
    rc_d    = rc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = cipher_if.Din;
          r_d     = 5'd0;
          rc_d    = RC_INIT;
        end
      end
      RUN: begin
        s_d  = round_out;
        r_d  = r_q + 5'd1;
        rc_d = rc_step;
        // The final round result goes straight to Dout so it is valid during DONE.
        if (r_q == LAST_ROUND) begin
          state_d = DONE;
          dout_d  = round_out;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      dout_q      <= '0;
      r_q         <= '0;
      rc_q        <= '0;
      din_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      dout_q      <= dout_d;
      r_q         <= r_d;
      rc_q        <= rc_d;
      din_valid_q <= cipher_if.Din_valid;
    end
  end

  assign cipher_if.Dout       = dout_q;
  assign cipher_if.Dout_valid = (state_q == DONE);
  assign cipher_if.busy       = (state_q != IDLE);

`ifdef CIPHER_OVERRUN_EN
  logic overrun_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (start && (state_q != IDLE)) begin
      overrun_q <= 1'b1;
    end
  end
  assign overrun = overrun_q;
`endif

endmodule
